// File: rtl/lfsr_counter_if.sv
// Control/status bundle for lfsr_counter.
// master drives the controls, slave is the counter itself.
interface lfsr_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             match_en;
    logic [WIDTH-1:0] match;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             lock_err;

    modport master (
        output en, load, seed, match_en, match,
        input  q, tc, lock_err
    );

    modport slave (
        input  en, load, seed, match_en, match,
        output q, tc, lock_err
    );
endinterface

// File: rtl/lfsr_counter.sv
// Fibonacci XNOR LFSR counter with free-run and modulus modes.
// All-ones is the lock-up state; it is never loaded or stepped into.
module xnor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a ^ b);
endmodule

module lfsr_counter #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    lfsr_counter_if.slave bus
);
    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_counter: WIDTH must be within 3..16");
    end

    // 1-based tap k of the maximal-length polynomial; 0 = unused slot.
    function automatic int tap_pos(input int w, input int k);
        int t0, t1, t2, t3;
        t2 = 0;
        t3 = 0;
        case (w)
            3:  begin t0 = 3;  t1 = 2;  end
            4:  begin t0 = 4;  t1 = 3;  end
            5:  begin t0 = 5;  t1 = 3;  end
            6:  begin t0 = 6;  t1 = 5;  end
            7:  begin t0 = 7;  t1 = 6;  end
            8:  begin t0 = 8;  t1 = 6;  t2 = 5; t3 = 4; end
            9:  begin t0 = 9;  t1 = 5;  end
            10: begin t0 = 10; t1 = 7;  end
            11: begin t0 = 11; t1 = 9;  end
            12: begin t0 = 12; t1 = 6;  t2 = 4; t3 = 1; end
            13: begin t0 = 13; t1 = 4;  t2 = 3; t3 = 1; end
            14: begin t0 = 14; t1 = 5;  t2 = 3; t3 = 1; end
            15: begin t0 = 15; t1 = 14; end
            16: begin t0 = 16; t1 = 15; t2 = 13; t3 = 4; end
            default: begin t0 = 3; t1 = 2; end
        endcase
        case (k)
            0:       return t0;
            1:       return t1;
            2:       return t2;
            default: return t3;
        endcase
    endfunction

    localparam int NT = (tap_pos(WIDTH, 2) == 0) ? 2 : 4;

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             lock_r;
    logic [NT-1:0]    chain;
    logic             fb;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] reload;
    logic             seed_ones;
    logic             hit;
    logic             do_load;
    logic             do_wrap;
    logic             do_step;

    // An odd number of chained 2-input XNORs yields the XNOR of all taps.
    assign chain[0] = q_r[tap_pos(WIDTH, 0) - 1];

    for (genvar i = 1; i < NT; i++) begin : g_fb
        xnor_gate u_xnor (
            .a (chain[i-1]),
            .b (q_r[tap_pos(WIDTH, i) - 1]),
            .y (chain[i])
        );
    end

    assign fb        = chain[NT-1];
    assign q_nxt     = {q_r[WIDTH-2:0], fb};
    assign seed_ones = &bus.seed;
    assign reload    = seed_ones ? '0 : bus.seed;
    assign hit       = (q_r == bus.match);

    assign do_load = bus.load;
    assign do_wrap = !bus.load && bus.en && bus.match_en && hit;
    assign do_step = !bus.load && bus.en && !(bus.match_en && hit);

    // State, terminal-count and sticky lock-up flag; load beats wrap beats step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= '0;
            tc_r   <= 1'b0;
            lock_r <= 1'b0;
        end else begin
            unique case (1'b1)
                do_load: begin
                    q_r    <= reload;
                    tc_r   <= 1'b0;
                    lock_r <= seed_ones;
                end
                do_wrap: begin
                    q_r  <= reload;
                    tc_r <= 1'b1;
                    if (seed_ones) begin
                        lock_r <= 1'b1;
                    end
                end
                do_step: begin
                    q_r  <= q_nxt;
                    tc_r <= 1'b0;
                end
                default: begin
                    tc_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q        = q_r;
    assign bus.tc       = tc_r;
    assign bus.lock_err = lock_r;
endmodule

// File: doc/lfsr_counter.md
# lfsr_counter

Pseudo-random state counter built on a Fibonacci LFSR with XNOR feedback. It is the sequential stage that consumes XNOR gate outputs as its feedback network. It provides a compact, glitch-light counter for the counters library. Supported modes are free-running (maximal period 2^WIDTH−1) and programmable-modulus, where the counter reloads a seed on reaching a match value and emits a terminal-count pulse.

## Interface
- WIDTH, 8, register width; legal range 3..16; any other value is a compile-time error.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  advance one LFSR step this cycle.
- load  input  1  synchronous load of `seed`; has priority over `en`.
- seed  input  WIDTH  load / reload value.
- match_en  input  1  1 = modulus mode (compare against `match`); 0 = free-run.
- match  input  WIDTH  terminal state compared against `q`.
- q  output  WIDTH  current LFSR state (registered).
- tc  output  1  terminal-count pulse (registered, one cycle).
- lock_err  output  1  sticky flag: an all-ones load was attempted.

## Operation
- Feedback: `fb` = XNOR of the tap bits. Next state = {q[WIDTH-2:0], fb}. Taps are 1-based, bit n = q[n-1].
- Maximal-length taps:
  - 3:(3,2), 4:(4,3), 5:(5,3), 6:(6,5), 7:(7,6), 8:(8,6,5,4)
  - 9:(9,5), 10:(10,7), 11:(11,9), 12:(12,6,4,1), 13:(13,4,3,1), 14:(14,5,3,1)
  - 15:(15,14), 16:(16,15,13,4)
- The multi-input XNOR is built as a chain of 2-input xnor_gate instances.
- The all-zeros state is legal. The all-ones state is the lock-up state and must never be entered.
- Per-cycle priority, highest first:
  1. `load`: q ← seed. If seed is all-ones, q ← 0 and lock_err ← 1. tc ← 0.
  2. `en` && `match_en` && q == match: q ← seed, tc ← 1. An all-ones seed is handled the same way as in rule 1, including setting lock_err.
  3. `en`: q ← next state, tc ← 0.
  4. Otherwise: q holds, tc ← 0.
- lock_err is cleared only by reset or by a `load` of a non-all-ones seed.
- A `match` value that is not in the seed's orbit never fires; the counter runs the full period. This is legal, not an error.
- `match` == all-ones can never match.
- Modulus mode period (in en-cycles) = distance from seed to match along the sequence, plus 1.

## Timing
- Reset (async assert, release synchronized externally): q = 0, tc = 0, lock_err = 0.
- Latency: all outputs are registered and update on the clk edge after the qualifying inputs. `q` reflects a load or step one cycle later.
- tc is high for exactly the one cycle in which q shows the reloaded seed. Back-to-back tc is possible when seed == match.
- `load` and a match in the same cycle: load wins, tc = 0.
- `en` low in a match cycle: no reload and no tc. The match is re-evaluated on the next `en`.
- Reset asserted mid-sequence: q and tc clear immediately. The next step after release is from 0.
- No combinational path from any input to any output.

## Test plan
- WIDTH=4, reset, en=1, match_en=0, 16 cycles -> q = 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0 (hex). tc never asserts. Period is 15.
- WIDTH=4, load seed=3, match_en=1, match=6, en=1 -> q = 3,7,E,D,B,6,3,7… tc high exactly in the cycles where q returns to 3. Period is 6.
- WIDTH=4, load seed=F -> q = 0, lock_err = 1. Then load seed=2 -> q = 2, lock_err = 0.
- load and match coincide (q=6, match=6, load=1, seed=1) -> q = 1, tc = 0. Toggle en low on a match cycle -> q holds at 6, tc = 0.
- Assert rst_n=0 mid-run with q=B and lock_err=1 -> q, tc and lock_err are 0 immediately, without waiting for a clk edge.
- WIDTH=8 and WIDTH=16, free-run from 0 -> first return to 0 after 255 and 65535 steps respectively. All-ones is never observed.
